// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: two-beat read of the word pair at Addr/Addr+4 with ack timeout.
// Optional one-entry line buffer (1-cycle hit path) enabled by defining IFC_LINE_BUF_EN.
module inst_fetch_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic              Flush,
  output logic [DATA_W-1:0] Inst1_Data,
  output logic [DATA_W-1:0] Inst2_Data,
  output logic              Resp_Ready,
  output logic              Resp_Err,
  output logic              Mem_Rd,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [DATA_W-1:0] Mem_Rdata,
  input  logic              Mem_Ack
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RD0, RD1, DONE, ERR} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] inst1_q, inst2_q, word0_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              mem_rd_q, resp_ready_q, resp_err_q, abort_q;
  logic [CNT_W-1:0]  cnt_q;

`ifdef IFC_LINE_BUF_EN
  logic              buf_valid_q;
  logic [ADDR_W-3:0] tag_q, pend_tag_q;
  logic [DATA_W-1:0] buf0_q, buf1_q;
`endif

  logic [ADDR_W-1:0] req_aligned_d, addr_inc_d;
  logic [CNT_W-1:0]  cnt_inc_d;
  logic              timeout_d, abort_d, ack_d, hit_d;

  always_comb begin
    req_aligned_d = Req_Addr & ~ADDR_W'(3);
    addr_inc_d    = mem_addr_q + ADDR_W'(4);
    cnt_inc_d     = cnt_q + CNT_W'(1);
    timeout_d     = (cnt_inc_d == CNT_W'(ACK_TIMEOUT));
    // A Flush landing on the final ack still suppresses the response.
    abort_d       = abort_q | Flush;
    ack_d         = Mem_Ack & mem_rd_q;
`ifdef IFC_LINE_BUF_EN
    hit_d         = buf_valid_q && (req_aligned_d[ADDR_W-1:2] == tag_q);
`else
    hit_d         = 1'b0;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= IDLE;
      inst1_q      <= '0;
      inst2_q      <= '0;
      word0_q      <= '0;
      mem_addr_q   <= '0;
      mem_rd_q     <= 1'b0;
      resp_ready_q <= 1'b0;
      resp_err_q   <= 1'b0;
      abort_q      <= 1'b0;
      cnt_q        <= '0;
`ifdef IFC_LINE_BUF_EN
      buf_valid_q  <= 1'b0;
      tag_q        <= '0;
      pend_tag_q   <= '0;
      buf0_q       <= '0;
      buf1_q       <= '0;
`endif
    end else begin
      resp_ready_q <= 1'b0;
      resp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Req && !Flush) begin
            if (hit_d) begin
`ifdef IFC_LINE_BUF_EN
              inst1_q      <= buf0_q;
              inst2_q      <= buf1_q;
`endif
              resp_ready_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              mem_addr_q <= req_aligned_d;
              mem_rd_q   <= 1'b1;
              cnt_q      <= '0;
`ifdef IFC_LINE_BUF_EN
              pend_tag_q <= req_aligned_d[ADDR_W-1:2];
`endif
              state_q    <= RD0;
            end
          end
        end
        RD0, RD1: begin
          if (Flush) abort_q <= 1'b1;
          // An ack in the limit cycle takes priority over the timeout.
          if (ack_d) begin
            cnt_q <= '0;
            if (state_q == RD0) begin
              word0_q    <= Mem_Rdata;
              mem_addr_q <= addr_inc_d;
              state_q    <= RD1;
            end else begin
              mem_rd_q <= 1'b0;
              if (!abort_d) begin
                inst1_q      <= word0_q;
                inst2_q      <= Mem_Rdata;
                resp_ready_q <= 1'b1;
`ifdef IFC_LINE_BUF_EN
                buf0_q       <= word0_q;
                buf1_q       <= Mem_Rdata;
                tag_q        <= pend_tag_q;
                buf_valid_q  <= 1'b1;
`endif
              end
              state_q <= DONE;
            end
          end else if (timeout_d) begin
            cnt_q      <= cnt_inc_d;
            mem_rd_q   <= 1'b0;
            resp_err_q <= 1'b1;
            state_q    <= ERR;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        DONE: begin
          abort_q <= 1'b0;
          state_q <= IDLE;
        end
        ERR: begin
          abort_q <= 1'b0;
`ifdef IFC_LINE_BUF_EN
          buf_valid_q <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Inst1_Data = inst1_q;
  assign Inst2_Data = inst2_q;
  assign Resp_Ready = resp_ready_q;
  assign Resp_Err   = resp_err_q;
  assign Mem_Rd     = mem_rd_q;
  assign Mem_Addr   = mem_addr_q;

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Instruction-side memory controller that sits directly upstream of the processor top.
- Accepts the fetch request (address plus request strobe) and returns the instruction pair for Addr and Addr+4, together with a Ready flag.
- Internally runs a two-beat read FSM against a single-word backing-memory port.
- Includes a one-entry line buffer and an acknowledge timeout.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, instruction and memory word width in bits.
- ACK_TIMEOUT, 64, maximum cycles to wait for Mem_Ack per beat before the fetch is aborted; must be ≥ 2.

Ports:
- Clk  in  1  system clock (System.Clk).
- Rst  in  1  synchronous active-high reset (System.Rst).
- Req  in  1  fetch request strobe; sampled only in IDLE.
- Req_Addr  in  ADDR_W  fetch PC; bits [1:0] ignored.
- Flush  in  1  abort the current fetch.
- Inst1_Data  out  DATA_W  instruction at Addr.
- Inst2_Data  out  DATA_W  instruction at Addr+4.
- Resp_Ready  out  1  one-cycle pulse; the instruction pair is valid.
- Resp_Err  out  1  one-cycle pulse; the fetch timed out.
- Mem_Rd  out  1  backing-memory read strobe.
- Mem_Addr  out  ADDR_W  word-aligned backing-memory address.
- Mem_Rdata  in  DATA_W  backing-memory read data.
- Mem_Ack  in  1  read data valid; meaningful only while Mem_Rd=1.

Behaviour:
- Clock and reset: one clock (Clk); reset (Rst) is synchronous and active-high.
- Reset values:
  - State = IDLE.
  - Resp_Ready=0, Resp_Err=0, Mem_Rd=0.
  - Mem_Addr=0, Inst1_Data=0, Inst2_Data=0.
  - Buffer valid=0, abort flag=0, timeout counter=0.
  - Reset mid-fetch drops the transaction immediately and Mem_Rd=0 the next cycle.
- All outputs are registered.
- States: IDLE, RD0, RD1, DONE, ERR.
- IDLE:
  - Req=0 → stay in IDLE.
  - Req=1 and hit (buffer valid and Req_Addr[31:2]==tag) → load the buffered pair into Inst1_Data/Inst2_Data → DONE. Hit latency is 1 cycle.
  - Req=1 and miss → latch A={Req_Addr[31:2],2'b00}, Mem_Addr=A, Mem_Rd=1 → RD0.
- RD0:
  - Hold Mem_Rd=1 and Mem_Addr stable until Mem_Ack.
  - On Mem_Ack: word0=Mem_Rdata, Mem_Addr=A+4 (mod 2^ADDR_W; 0xFFFFFFFC wraps to 0x00000000), Mem_Rd stays 1 → RD1.
- RD1:
  - On Mem_Ack: word1=Mem_Rdata, Mem_Rd=0 → DONE.
- Minimum miss latency: with zero-wait Ack, Req sampled in cycle 0 → Resp_Ready in cycle 3.
- DONE:
  - Resp_Ready=1 for exactly one cycle unless the abort flag is set.
  - On a miss completion: Inst1_Data=word0, Inst2_Data=word1, tag=A[31:2], buffer valid=1.
  - Next state is IDLE.
  - Req is not re-sampled in DONE; back-to-back requests are separated by at least one IDLE cycle.
- Data hold: Inst1_Data and Inst2_Data hold their last value until the next non-aborted DONE.
- Flush:
  - In RD0/RD1 → set the abort flag. The memory transaction still completes (Mem_Rd is never dropped before Ack).
  - In DONE with the abort flag set → no Resp_Ready, buffer and data outputs unchanged, abort flag cleared.
  - In IDLE → no effect beyond the current cycle.
  - Flush and Req in the same IDLE cycle → Flush wins; the request is ignored.
- Timeout:
  - The counter clears on entry to RD0 and on each Ack, and increments every RD0/RD1 cycle without Ack.
  - On reaching ACK_TIMEOUT → Mem_Rd=0, go to ERR.
  - ERR: Resp_Err=1 for one cycle, buffer valid=0, abort flag cleared → IDLE.
  - Ack arriving in the same cycle the limit is reached counts as an Ack; no error.
- Mem_Ack while Mem_Rd=0 is ignored.

Optional Feature:
- Macro: IFC_LINE_BUF_EN.
- Defined: the one-entry line buffer and the 1-cycle hit path exist as described.
- Undefined: no tag or buffer storage; every request is a miss through RD0/RD1; buffer updates in DONE/ERR are removed. All other timing is identical.

Test Plan:
- Reset, then Req=1, Req_Addr=0x00000100, zero-wait Ack with Rdata 0x11111111 then 0x22222222 → Mem_Addr 0x100 then 0x104; Resp_Ready in cycle 3 with Inst1=0x11111111, Inst2=0x22222222.
- Repeat Req at 0x00000102 with IFC_LINE_BUF_EN → Resp_Ready 1 cycle later with the same pair and Mem_Rd never asserted. Without the macro → full miss sequence.
- Req_Addr=0xFFFFFFFC → Mem_Addr 0xFFFFFFFC then 0x00000000; pair returned correctly.
- Ack delayed 5 cycles per beat → Mem_Rd and Mem_Addr held stable throughout; Resp_Ready in cycle 13.
- Flush asserted in RD1 → transaction completes; no Resp_Ready; outputs keep the previous pair; a following Req at the same address is a miss.
- ACK_TIMEOUT=4, Ack never driven → Mem_Rd drops after 4 RD0 cycles; Resp_Err pulses once; buffer invalidated; FSM returns to IDLE.
